// File: rtl/axi_xbar_pkg.sv
// Shared types and helpers for the crossbar demux.
// Holds AXI resp encodings, resp_t and the port-index width helper.
package axi_xbar_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [1:0] resp_t;

  // Index width for n ports, never below 1 bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter; search starts at rr_q, rr_q moves past the winner.
// Ports: clk_i, rst_i, req_i[N], en_i -> gnt_o[N] one-hot, idx_o winner.
module axi_rr_arbiter
  import axi_xbar_pkg::*;
#(
  parameter int unsigned N  = 4,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] rr_q, rr_d;
  logic          found;
  int unsigned   p;
  logic [IW-1:0] pidx;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    p     = 0;
    pidx  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      p = 32'(rr_q) + i;
      if (p >= N) p = p - N;
      pidx = IW'(p);
      if (!found && req_i[pidx]) begin
        found       = 1'b1;
        gnt_o[pidx] = 1'b1;
        idx_o       = pidx;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (en_i && |req_i) begin
      if (32'(idx_o) == N - 1) rr_d = '0;
      else                     rr_d = idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/axi_b_resp_arbiter.sv
// B-channel merge: round-robin over downstream ports into a one-entry
// output register; pops the in-flight array on every upstream B beat.
// Ports: mst_b_* (NoMstPorts downstream), slv_b_* (upstream), pop_*.
module axi_b_resp_arbiter
  import axi_xbar_pkg::*;
#(
  parameter int unsigned NoMstPorts   = 4,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiLookBits  = 3,
  parameter int unsigned AxiUserWidth = 1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NoMstPorts-1:0]                    mst_b_valid_i,
  input  logic [NoMstPorts-1:0][AxiIdWidth-1:0]    mst_b_id_i,
  input  logic [NoMstPorts-1:0][1:0]               mst_b_resp_i,
  input  logic [NoMstPorts-1:0][AxiUserWidth-1:0]  mst_b_user_i,
  output logic [NoMstPorts-1:0]                    mst_b_ready_o,
  output logic                                     slv_b_valid_o,
  output logic [AxiIdWidth-1:0]                    slv_b_id_o,
  output logic [1:0]                               slv_b_resp_o,
  output logic [AxiUserWidth-1:0]                  slv_b_user_o,
  input  logic                                     slv_b_ready_i,
  output logic                                     pop_en_o,
  output logic [AxiLookBits-1:0]                   pop_axi_id_o
);

  localparam int unsigned IdxW = idx_width(NoMstPorts);

  logic                    load;
  logic                    grant_en;
  logic                    hs_dn;
  logic [NoMstPorts-1:0]   gnt;
  logic [IdxW-1:0]         idx;

  logic                    full_q, full_d;
  logic [AxiIdWidth-1:0]   id_q, id_d;
  resp_t                   resp_q, resp_d;
  logic [AxiUserWidth-1:0] user_q, user_d;

  // Register may take a new beat when empty or when it drains this cycle.
  assign load     = ~full_q | slv_b_ready_i;
  assign grant_en = load & ~rst_i;

  axi_rr_arbiter #(
    .N (NoMstPorts)
  ) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (mst_b_valid_i),
    .en_i  (grant_en),
    .gnt_o (gnt),
    .idx_o (idx)
  );

  assign mst_b_ready_o = gnt & {NoMstPorts{grant_en}};
  assign hs_dn         = grant_en & |mst_b_valid_i;

  always_comb begin
    full_d = full_q;
    id_d   = id_q;
    resp_d = resp_q;
    user_d = user_q;
    if (hs_dn) begin
      // Also covers drain-and-refill in one cycle.
      full_d = 1'b1;
      id_d   = mst_b_id_i[idx];
      resp_d = mst_b_resp_i[idx];
      user_d = mst_b_user_i[idx];
    end else if (full_q && slv_b_ready_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      id_q   <= '0;
      resp_q <= '0;
      user_q <= '0;
    end else begin
      full_q <= full_d;
      id_q   <= id_d;
      resp_q <= resp_d;
      user_q <= user_d;
    end
  end

  // Reset hides a buffered beat at once, so no pop escapes during reset.
  assign slv_b_valid_o = full_q & ~rst_i;
  assign slv_b_id_o    = rst_i ? '0 : id_q;
  assign slv_b_resp_o  = rst_i ? '0 : resp_q;
  assign slv_b_user_o  = rst_i ? '0 : user_q;

  assign pop_en_o     = slv_b_valid_o & slv_b_ready_i;
  assign pop_axi_id_o = slv_b_id_o[AxiLookBits-1:0];

endmodule

// File: tb/tb_axi_b_resp_arbiter.sv
// Directed and random checks of axi_b_resp_arbiter against a
// queue-free behavioural model of the merge register.
module tb_axi_b_resp_arbiter;
  import axi_xbar_pkg::*;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int LB = 3;
  localparam int UW = 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          vld;
  logic [N-1:0][IW-1:0]  id;
  logic [N-1:0][1:0]     resp;
  logic [N-1:0][UW-1:0]  user;
  logic [N-1:0]          mrdy;
  logic                  sv;
  logic [IW-1:0]         sid;
  logic [1:0]            sresp;
  logic [UW-1:0]         suser;
  logic                  sr;
  logic                  pop_en;
  logic [LB-1:0]         pop_id;

  always #5 clk = ~clk;

  axi_b_resp_arbiter #(
    .NoMstPorts   (N),
    .AxiIdWidth   (IW),
    .AxiLookBits  (LB),
    .AxiUserWidth (UW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mst_b_valid_i (vld),
    .mst_b_id_i    (id),
    .mst_b_resp_i  (resp),
    .mst_b_user_i  (user),
    .mst_b_ready_o (mrdy),
    .slv_b_valid_o (sv),
    .slv_b_id_o    (sid),
    .slv_b_resp_o  (sresp),
    .slv_b_user_o  (suser),
    .slv_b_ready_i (sr),
    .pop_en_o      (pop_en),
    .pop_axi_id_o  (pop_id)
  );

  int n_assert = 0;
  int n_fail   = 0;

  bit            m_full = 1'b0;
  int            m_rr   = 0;
  logic [IW-1:0] m_id   = '0;
  logic [1:0]    m_resp = '0;
  logic [UW-1:0] m_user = '0;
  int            m_g    = -1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Evaluate outputs for current inputs against the model.
  task automatic settle();
    bit          found;
    bit          vo;
    logic [31:0] er;
    #1;
    m_g   = -1;
    found = 1'b0;
    if (!rst && (!m_full || sr)) begin
      for (int i = 0; i < N; i++) begin
        int p;
        p = (m_rr + i) % N;
        if (!found && vld[p]) begin
          found = 1'b1;
          m_g   = p;
        end
      end
    end
    er = (m_g < 0) ? 32'd0 : (32'd1 << m_g);
    vo = m_full && !rst;
    chk("m_ready", mrdy, er);
    chk("m_valid", sv, vo);
    chk("m_id", sid, rst ? 0 : m_id);
    chk("m_resp", sresp, rst ? 0 : m_resp);
    chk("m_user", suser, rst ? 0 : m_user);
    chk("m_pop", pop_en, vo && sr);
    chk("m_popid", pop_id, rst ? 0 : m_id % (1 << LB));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_full = 1'b0;
      m_rr   = 0;
      m_id   = '0;
      m_resp = '0;
      m_user = '0;
    end else if (m_g >= 0) begin
      m_full = 1'b1;
      m_id   = id[m_g];
      m_resp = resp[m_g];
      m_user = user[m_g];
      m_rr   = (m_g + 1) % N;
    end else if (m_full && sr) begin
      m_full = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic put(input int p, input logic [IW-1:0] i,
                     input logic [1:0] r, input logic [UW-1:0] u);
    vld[p]  = 1'b1;
    id[p]   = i;
    resp[p] = r;
    user[p] = u;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld = '0;
    sr  = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    vld  = '0;
    id   = '0;
    resp = '0;
    user = '0;
    sr   = 1'b0;
    vld[0] = 1'b1;
    @(negedge clk);
    settle();
    chk("rst_ready", mrdy, 0);
    chk("rst_valid", sv, 0);
    tick();
    settle();
    chk("rst_pop", pop_en, 0);
    tick();
    rst = 1'b0;
    vld = '0;
    step();

    // Single beat from port 2
    put(2, 4'h5, RESP_OKAY, 1'b0);
    sr = 1'b1;
    settle();
    chk("t1_gnt", mrdy, 4'b0100);
    tick();
    vld = '0;
    settle();
    chk("t1_valid", sv, 1);
    chk("t1_id", sid, 4'h5);
    chk("t1_pop", pop_en, 1);
    chk("t1_popid", pop_id, 3'd5);
    tick();

    // All ports streaming
    do_reset();
    for (int p = 0; p < N; p++) put(p, 4'(p + 8), 2'(p), 1'(p));
    sr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t2_gnt", mrdy, 32'd1 << (k % 4));
      if (k > 0) chk("t2_pop", pop_en, 1);
      tick();
    end
    vld = '0;
    step();

    // Back-pressure hold, then drain with same-cycle refill
    do_reset();
    put(1, 4'hA, RESP_SLVERR, 1'b1);
    sr = 1'b0;
    step();
    vld = '0;
    put(0, 4'h3, RESP_EXOKAY, 1'b0);
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t3_ready", mrdy, 0);
      chk("t3_pop", pop_en, 0);
      chk("t3_id", sid, 4'hA);
      chk("t3_resp", sresp, RESP_SLVERR);
      tick();
    end
    sr = 1'b1;
    settle();
    chk("t3_rel_pop", pop_en, 1);
    chk("t3_rel_popid", pop_id, 3'd2);
    chk("t5_refill_gnt", mrdy, 4'b0001);
    tick();
    vld = '0;
    settle();
    chk("t5_valid", sv, 1);
    chk("t5_id", sid, 4'h3);
    tick();
    settle();
    chk("t5_empty", sv, 0);
    tick();

    // Round-robin from pointer 1
    do_reset();
    put(0, 4'h1, RESP_OKAY, 1'b0);
    sr = 1'b1;
    step();
    vld = '0;
    step();
    put(0, 4'h2, RESP_OKAY, 1'b0);
    put(3, 4'h9, RESP_DECERR, 1'b1);
    settle();
    chk("t4_gnt3", mrdy, 4'b1000);
    tick();
    vld[3] = 1'b0;
    settle();
    chk("t4_gnt0", mrdy, 4'b0001);
    chk("t4_id3", sid, 4'h9);
    tick();
    vld = '0;
    step();
    step();

    // Reset with a buffered beat
    put(2, 4'h7, RESP_DECERR, 1'b1);
    sr = 1'b0;
    step();
    vld = '0;
    settle();
    chk("t6_full", sv, 1);
    tick();
    rst = 1'b1;
    settle();
    chk("t6_rst_pop", pop_en, 0);
    tick();
    rst = 1'b0;
    vld = '1;
    settle();
    chk("t6_valid", sv, 0);
    chk("t6_pop", pop_en, 0);
    chk("t6_rr0", mrdy, 4'b0001);
    tick();
    vld = '0;
    sr  = 1'b1;
    step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 49) == 0);
      vld  = N'($urandom);
      for (int p = 0; p < N; p++) begin
        id[p]   = IW'($urandom);
        resp[p] = 2'($urandom);
        user[p] = UW'($urandom);
      end
      sr = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
